rnn_mac_accumulator: RTL and testbench
======================================

Name: rnn_mac_accumulator

Overview:
- Sequential dot-product engine for one RNN neuron: acc = BIAS + sum(W_i * X_i), i = 0..LEN-1.
- Consumes a stream of 8-bit weights (1_2_5) and 16-bit activations (1_2_13).
- Accumulates into 20-bit 1_6_13 with saturation.
- Presents both the 20-bit sum and a 16-bit saturated sum to the downstream activation/ALU stage via valid/ready.

Parameters:
- MAX_LEN, 64, maximum terms per dot product.
- LEN_W, 7, width of LEN; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request new dot product; accepted when START & START_READY.
- START_READY  output  1  high only in IDLE.
- BIAS  input  16  1_2_13 bias; sampled on START accept.
- LEN  input  LEN_W  term count 0..MAX_LEN; sampled on START accept.
- IN_VALID  input  1  W_IN/X_IN valid.
- IN_READY  output  1  high only in RUN.
- W_IN  input  8  weight, signed 1_2_5.
- X_IN  input  16  activation, signed 1_2_13.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts result.
- ACC_OUT  output  20  signed 1_6_13 sum.
- OUT16  output  16  ACC_OUT saturated to 1_2_13.
- SAT20  output  1  sticky: some accumulate step saturated 20-bit.
- SAT16  output  1  OUT16 was clipped.

Behaviour:
- Reset: state IDLE; ACC, product register, count, flags = 0.
- Reset value of all outputs: START_READY=1, all other outputs 0.
- RST asserted mid-operation aborts immediately; the partial sum is discarded.
- FSM states: IDLE, RUN, DRAIN, OUT.
- IDLE, on START accept:
  - ACC <= sign-extend(BIAS) to 20 bits; count <= 0; SAT20 <= 0; latch LEN.
  - LEN==0 -> OUT; else -> RUN.
  - LEN > MAX_LEN is clamped to MAX_LEN.
- RUN:
  - IN_READY=1; each IN_VALID cycle is one accepted beat.
  - Stage 1, on beat: P = signed(W_IN) * signed(X_IN), 24-bit, 18 fraction bits.
  - Stage 1 register: TERM <= P arithmetic-shifted right by 5 (floor, no rounding), sign-extended to 20 bits. TERM is always in range, never saturates. Set TVLD <= 1.
  - Stage 2, every cycle with TVLD=1: ACC <= sat20(ACC + TERM).
  - sat20: exact 21-bit sum; positive overflow -> 0x7FFFF, negative -> 0x80000, and SAT20 <= 1.
  - TVLD clears when no beat is accepted that cycle.
  - On the beat where count reaches LEN -> DRAIN. No further beats are accepted: IN_READY=0 from the next cycle.
- DRAIN: one cycle; performs the final accumulate -> OUT.
- OUT:
  - OUT_VALID=1. ACC_OUT, OUT16, SAT20 and SAT16 are held stable until OUT_READY.
  - OUT_VALID & OUT_READY -> IDLE; START_READY returns the next cycle.
- OUT16 / SAT16:
  - ACC[19:15] all equal -> OUT16 = ACC[15:0], SAT16 = 0.
  - Else OUT16 = 0x7FFF (ACC>0) or 0x8000 (ACC<0), SAT16 = 1.
- Latency:
  - OUT_VALID rises 2 cycles after the edge that accepts the last beat.
  - With LEN==0, OUT_VALID rises 1 cycle after the START accept edge.
- Gaps: IN_VALID low in RUN stalls without effect; the sum is independent of gap pattern.
- START asserted outside IDLE is ignored and not queued.
- IN_VALID outside RUN is ignored.

Test Plan:
- Basic sum:
  - Stimulus: BIAS=0x0000, LEN=3; beats (W 0x20, X 0x2000), (0x20, 0x1000), (0xE0, 0x0800), back-to-back.
  - Response: ACC_OUT=0x02800, OUT16=0x2800, SAT16=SAT20=0; OUT_VALID 2 cycles after the 3rd beat.
- LEN=0:
  - Stimulus: BIAS=0xF000.
  - Response: OUT_VALID 1 cycle after START; ACC_OUT=0xFF000, OUT16=0xF000.
- Floor truncation:
  - Stimulus: BIAS=0, LEN=1, W=0xFF, X=0x0001.
  - Response: ACC_OUT=0xFFFFF, OUT16=0xFFFF.
- 16-bit clip:
  - Stimulus: BIAS=0, LEN=2, both beats W=0x7F, X=0x7FFF (term 0x1FBFC).
  - Response: ACC_OUT=0x3F7F8, OUT16=0x7FFF, SAT16=1, SAT20=0.
- 20-bit saturation:
  - Stimulus: same beat pattern, LEN=5.
  - Response: ACC_OUT=0x7FFFF, SAT20=1, OUT16=0x7FFF, SAT16=1.
- Handshake, stall and reset:
  - Stimulus: basic sum with IN_VALID gaps and OUT_READY low for 5 cycles; START pulsed in RUN; then RST mid-RUN.
  - Response: the stalled run gives the same 0x02800, OUTs held stable while OUT_READY is low, the START pulse in RUN is ignored; after RST all outputs are 0, START_READY=1, and the next run is correct.

Source files
------------

// File: rtl/rnn_mac_accumulator.sv
// Sequential dot-product engine for one RNN neuron: acc = bias + sum(w_i * x_i).
// Two-stage pipeline (multiply/scale, then saturating accumulate) behind a four-state handshake FSM.
module rnn_mac_accumulator #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             start_ready,
    input  logic [15:0]      bias,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       w_in,
    input  logic [15:0]      x_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [19:0]      acc_out,
    output logic [15:0]      out16,
    output logic             sat20,
    output logic             sat16
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    localparam logic [19:0] ACC_MAX = 20'h7FFFF;
    localparam logic [19:0] ACC_MIN = 20'h80000;

    state_t             state, state_next;
    logic               start_accept, beat, last_beat;
    logic [LEN_W-1:0]   len_clamped, len_q, count, count_inc;
    logic signed [23:0] prod;
    logic [19:0]        term, acc, acc_next;
    logic [20:0]        sum21;
    logic               tvld, acc_ovf, clip16;

    // Qualify handshakes on state directly so the FSM outputs never feed back into themselves.
    assign start_accept = start && (state == IDLE);
    assign beat         = in_valid && (state == RUN);
    assign count_inc    = count + LEN_W'(1);
    assign last_beat    = beat && (count_inc == len_q);
    assign len_clamped  = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;

    // 1_2_5 * 1_2_13 gives 18 fraction bits; the term keeps 13 of them.
    assign prod = 24'($signed(w_in)) * 24'($signed(x_in));

    assign sum21    = {acc[19], acc} + {term[19], term};
    assign acc_ovf  = sum21[20] ^ sum21[19];
    assign acc_next = acc_ovf ? (sum21[20] ? ACC_MIN : ACC_MAX) : sum21[19:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        start_ready = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start) state_next = (len_clamped == '0) ? OUT : RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (last_beat) state_next = DRAIN;
            end
            DRAIN: state_next = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            term  <= '0;
            tvld  <= 1'b0;
            count <= '0;
            len_q <= '0;
            sat20 <= 1'b0;
        end else begin
            tvld <= beat;
            if (beat) begin
                term  <= 20'(prod >>> 5);
                count <= count_inc;
            end
            if (start_accept) begin
                acc   <= {{4{bias[15]}}, bias};
                count <= '0;
                sat20 <= 1'b0;
                len_q <= len_clamped;
            end else if (tvld) begin
                acc <= acc_next;
                if (acc_ovf) sat20 <= 1'b1;
            end
        end
    end

    // The 16-bit view is exact only when the five top bits are pure sign copies.
    assign clip16  = !((&acc[19:15]) || !(|acc[19:15]));
    assign acc_out = acc;
    assign sat16   = clip16;
    assign out16   = clip16 ? (acc[19] ? 16'h8000 : 16'h7FFF) : acc[15:0];

endmodule

// File: tb/tb_rnn_mac_accumulator.sv
// Self-checking bench for rnn_mac_accumulator: directed cases from the neuron's
// arithmetic rules plus randomized runs scored against an integer reference model.
module tb_rnn_mac_accumulator;

    typedef struct packed {
        logic [19:0] acc;
        logic [15:0] o16;
        logic        s20;
        logic        s16;
    } res_t;

    typedef struct packed {
        res_t       res;
        logic [7:0] lat;
        logic       rdy_ok;
        logic       stable;
        logic       idle;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start_ready;
    logic [15:0] bias = '0;
    logic [6:0]  len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  w_in = '0;
    logic [15:0] x_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] acc_out;
    logic [15:0] out16;
    logic        sat20;
    logic        sat16;

    logic [7:0]  w_arr[64];
    logic [15:0] x_arr[64];
    int          n_total = 0;
    int          n_pass  = 0;

    rnn_mac_accumulator #(.MAX_LEN(64), .LEN_W(7)) dut (
        .clk(clk), .rst(rst),
        .start(start), .start_ready(start_ready), .bias(bias), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .w_in(w_in), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .out16(out16), .sat20(sat20), .sat16(sat16)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, got timeout exp completion");
        $fatal(1);
    end

    // Reference: plain integer arithmetic, floor-scaled terms, clamp after every add.
    function automatic obs_t model(input logic [15:0] b, input int n);
        obs_t e;
        int   a, p;
        bit   s;
        a = int'($signed(b));
        s = 1'b0;
        for (int i = 0; i < n; i++) begin
            p = int'($signed(w_arr[i])) * int'($signed(x_arr[i]));
            a = a + (p >>> 5);
            if (a > 524287)       begin a = 524287;  s = 1'b1; end
            else if (a < -524288) begin a = -524288; s = 1'b1; end
        end
        e = '0;
        e.res.acc = a[19:0];
        e.res.s20 = s;
        if (a > 32767)       begin e.res.o16 = 16'h7FFF; e.res.s16 = 1'b1; end
        else if (a < -32768) begin e.res.o16 = 16'h8000; e.res.s16 = 1'b1; end
        else                 begin e.res.o16 = a[15:0];  e.res.s16 = 1'b0; end
        e.lat    = (n == 0) ? 8'd1 : 8'd2;
        e.rdy_ok = 1'b1;
        e.stable = 1'b1;
        e.idle   = 1'b1;
        return e;
    endfunction

    // Drives one full transaction and reports what the DUT did; all judging happens in the callers.
    task automatic run_dot(input logic [15:0] b, input logic [6:0] l, input int n,
                           input bit gaps, input int hold, input bit poke, output obs_t r);
        res_t snap;
        int   g;
        r = '0;
        r.rdy_ok = 1'b1;
        r.stable = 1'b1;
        if (poke) begin
            in_valid = 1'b1; w_in = 8'($urandom); x_in = 16'($urandom);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        if (!start_ready) r.rdy_ok = 1'b0;
        start = 1'b1; bias = b; len = l;
        @(posedge clk); #1;
        start = 1'b0; bias = 16'($urandom); len = 7'($urandom);
        for (int i = 0; i < n; i++) begin
            g = (poke && i == 1) ? 1 : (gaps ? int'($urandom_range(0, 2)) : 0);
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0; w_in = 8'($urandom); x_in = 16'($urandom);
                start = poke && (k == 0);
                if (!in_ready) r.rdy_ok = 1'b0;
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (!in_ready) r.rdy_ok = 1'b0;
            in_valid = 1'b1; w_in = w_arr[i]; x_in = x_arr[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        r.lat = 8'd1;
        while (!out_valid && r.lat < 8'd20) begin
            @(posedge clk); #1;
            r.lat++;
        end
        if (in_ready) r.rdy_ok = 1'b0;
        snap = {acc_out, out16, sat20, sat16};
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            if (poke) begin
                in_valid = 1'b1; start = 1'b1; w_in = 8'($urandom); x_in = 16'($urandom);
            end
            @(posedge clk); #1;
            if (!out_valid || ({acc_out, out16, sat20, sat16} !== snap)) r.stable = 1'b0;
        end
        in_valid = 1'b0; start = 1'b0;
        r.res = {acc_out, out16, sat20, sat16};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        r.idle = start_ready && !out_valid;
    endtask

    task automatic load_basic();
        w_arr[0] = 8'h20; x_arr[0] = 16'h2000;
        w_arr[1] = 8'h20; x_arr[1] = 16'h1000;
        w_arr[2] = 8'hE0; x_arr[2] = 16'h0800;
    endtask

    task automatic test_reset();
        n_total++;
        if ({start_ready, in_ready, out_valid, acc_out, out16, sat20, sat16} !== {1'b1, 2'b00, 20'h0, 16'h0, 2'b00})
            $display("FAIL reset_outputs got %h exp %h",
                     {start_ready, in_ready, out_valid, acc_out, out16, sat20, sat16},
                     {1'b1, 2'b00, 20'h0, 16'h0, 2'b00});
        else n_pass++;
    endtask

    task automatic test_basic();
        obs_t r;
        load_basic();
        run_dot(16'h0000, 7'd3, 3, 1'b0, 0, 1'b0, r);
        n_total++;
        if (r.res !== {20'h02800, 16'h2800, 2'b00}) $display("FAIL basic_result got %h exp %h", r.res, {20'h02800, 16'h2800, 2'b00});
        else n_pass++;
        n_total++;
        if (r.lat !== 8'd2) $display("FAIL basic_latency got %0d exp 2", r.lat);
        else n_pass++;
        n_total++;
        if ({r.rdy_ok, r.stable, r.idle} !== 3'b111) $display("FAIL basic_handshake got %b exp 111", {r.rdy_ok, r.stable, r.idle});
        else n_pass++;
    endtask

    task automatic test_len_zero();
        obs_t r;
        run_dot(16'hF000, 7'd0, 0, 1'b0, 2, 1'b0, r);
        n_total++;
        if (r.res !== {20'hFF000, 16'hF000, 2'b00}) $display("FAIL len0_result got %h exp %h", r.res, {20'hFF000, 16'hF000, 2'b00});
        else n_pass++;
        n_total++;
        if (r.lat !== 8'd1) $display("FAIL len0_latency got %0d exp 1", r.lat);
        else n_pass++;
        n_total++;
        if ({r.stable, r.idle} !== 2'b11) $display("FAIL len0_handshake got %b exp 11", {r.stable, r.idle});
        else n_pass++;
    endtask

    task automatic test_floor();
        obs_t r;
        w_arr[0] = 8'hFF; x_arr[0] = 16'h0001;
        run_dot(16'h0000, 7'd1, 1, 1'b0, 0, 1'b0, r);
        n_total++;
        if (r.res !== {20'hFFFFF, 16'hFFFF, 2'b00}) $display("FAIL floor_result got %h exp %h", r.res, {20'hFFFFF, 16'hFFFF, 2'b00});
        else n_pass++;
    endtask

    task automatic test_clip16();
        obs_t r;
        for (int i = 0; i < 5; i++) begin w_arr[i] = 8'h7F; x_arr[i] = 16'h7FFF; end
        run_dot(16'h0000, 7'd2, 2, 1'b0, 0, 1'b0, r);
        n_total++;
        if (r.res !== {20'h3F7F8, 16'h7FFF, 1'b0, 1'b1}) $display("FAIL clip16_result got %h exp %h", r.res, {20'h3F7F8, 16'h7FFF, 1'b0, 1'b1});
        else n_pass++;
    endtask

    task automatic test_sat20();
        obs_t r;
        for (int i = 0; i < 5; i++) begin w_arr[i] = 8'h7F; x_arr[i] = 16'h7FFF; end
        run_dot(16'h0000, 7'd5, 5, 1'b0, 0, 1'b0, r);
        n_total++;
        if (r.res !== {20'h7FFFF, 16'h7FFF, 2'b11}) $display("FAIL sat20_pos_result got %h exp %h", r.res, {20'h7FFFF, 16'h7FFF, 2'b11});
        else n_pass++;
        for (int i = 0; i < 5; i++) begin w_arr[i] = 8'h80; x_arr[i] = 16'h7FFF; end
        run_dot(16'h0000, 7'd5, 5, 1'b0, 0, 1'b0, r);
        n_total++;
        if (r.res !== {20'h80000, 16'h8000, 2'b11}) $display("FAIL sat20_neg_result got %h exp %h", r.res, {20'h80000, 16'h8000, 2'b11});
        else n_pass++;
    endtask

    task automatic test_stall();
        obs_t r;
        load_basic();
        run_dot(16'h0000, 7'd3, 3, 1'b1, 5, 1'b1, r);
        n_total++;
        if (r.res !== {20'h02800, 16'h2800, 2'b00}) $display("FAIL stall_result got %h exp %h", r.res, {20'h02800, 16'h2800, 2'b00});
        else n_pass++;
        n_total++;
        if ({r.rdy_ok, r.stable, r.idle} !== 3'b111) $display("FAIL stall_handshake got %b exp 111", {r.rdy_ok, r.stable, r.idle});
        else n_pass++;
        n_total++;
        if (r.lat !== 8'd2) $display("FAIL stall_latency got %0d exp 2", r.lat);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        obs_t r;
        load_basic();
        start = 1'b1; bias = 16'h1000; len = 7'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; w_in = w_arr[i]; x_in = x_arr[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_total++;
        if ({start_ready, in_ready, out_valid, acc_out, out16, sat20, sat16} !== {1'b1, 2'b00, 20'h0, 16'h0, 2'b00})
            $display("FAIL midrun_reset_outputs got %h exp %h",
                     {start_ready, in_ready, out_valid, acc_out, out16, sat20, sat16},
                     {1'b1, 2'b00, 20'h0, 16'h0, 2'b00});
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_dot(16'h0000, 7'd3, 3, 1'b0, 0, 1'b0, r);
        n_total++;
        if (r.res !== {20'h02800, 16'h2800, 2'b00}) $display("FAIL after_reset_result got %h exp %h", r.res, {20'h02800, 16'h2800, 2'b00});
        else n_pass++;
    endtask

    task automatic test_len_clamp();
        obs_t r, e;
        logic [15:0] b;
        logic [6:0]  lens[2];
        lens[0] = 7'd64;
        lens[1] = 7'd100;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 64; i++) begin
                w_arr[i] = 8'($urandom_range(0, 31)); x_arr[i] = 16'($urandom_range(0, 4095));
            end
            b = 16'($urandom);
            e = model(b, 64);
            run_dot(b, lens[t], 64, 1'b0, 0, 1'b0, r);
            n_total++;
            if (r.res !== e.res) $display("FAIL clamp_result len=%0d got %h exp %h", lens[t], r.res, e.res);
            else n_pass++;
            n_total++;
            if (r.lat !== e.lat) $display("FAIL clamp_latency len=%0d got %0d exp %0d", lens[t], r.lat, e.lat);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        obs_t r, e;
        logic [15:0] b;
        int n;
        for (int t = 0; t < 16; t++) begin
            n = $urandom_range(0, 8);
            for (int i = 0; i < n; i++) begin
                w_arr[i] = 8'($urandom);
                case ($urandom_range(0, 2))
                    0:       x_arr[i] = 16'h7FFF;
                    1:       x_arr[i] = 16'h8000;
                    default: x_arr[i] = 16'($urandom);
                endcase
            end
            b = 16'($urandom);
            e = model(b, n);
            run_dot(b, 7'(n), n, 1'b1, $urandom_range(0, 3), 1'($urandom), r);
            n_total++;
            if (r.res !== e.res) $display("FAIL random_result run=%0d got %h exp %h", t, r.res, e.res);
            else n_pass++;
            n_total++;
            if ({r.lat, r.rdy_ok, r.stable, r.idle} !== {e.lat, 3'b111})
                $display("FAIL random_timing run=%0d got %h exp %h", t, {r.lat, r.rdy_ok, r.stable, r.idle}, {e.lat, 3'b111});
            else n_pass++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_basic();
        test_len_zero();
        test_floor();
        test_clip16();
        test_sat20();
        test_stall();
        test_reset_mid_run();
        test_len_clamp();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
